multi_sprite_line_engine: RTL and testbench

//  Parametrised motion-sprite renderer: up to NUM_SPRITES 8x8 sprites per scanline, rendered one line ahead into

---
 rtl/sprite_engine_pkg.sv | 18 +
 rtl/sprite_line_bank.sv | 44 ++++
 rtl/multi_sprite_line_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_multi_sprite_line_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_engine_pkg.sv
// Shared types and constants for the multi-sprite line engine.
// Build option SPRITE_FLIP_EN turns on horizontal/vertical sprite flip.
package sprite_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] ATTR_X    = 2'd0;
    localparam logic [1:0] ATTR_Y    = 2'd1;
    localparam logic [1:0] ATTR_CTRL = 2'd2;

    localparam int SPRITE_DIM = 8;

endpackage

// File: rtl/sprite_line_bank.sv
// One scanline buffer: a single write port shared by the renderer and
// the display clear-on-read, plus one registered read port.
module sprite_line_bank #(
    parameter int DEPTH     = 320,
    parameter int DATA_BITS = 2,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 display,
    input  logic                 ren_we,
    input  logic [ADDR_BITS-1:0] ren_addr,
    input  logic [DATA_BITS-1:0] ren_data,
    input  logic                 clr_we,
    input  logic [ADDR_BITS-1:0] clr_addr,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 we;
    logic [ADDR_BITS-1:0] wa;
    logic [DATA_BITS-1:0] wd;

    // The bank's role decides who owns the write port this line.
    always_comb begin
        we = ren_we;
        wa = ren_addr;
        wd = ren_data;
        if (display) begin
            we = clr_we;
            wa = clr_addr;
            wd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/multi_sprite_line_engine.sv
// Renders up to NUM_SPRITES 8x8 sprites one line ahead into ping-pong
// line buffers. Build option SPRITE_FLIP_EN enables sprite flipping.
module multi_sprite_line_engine
    import sprite_engine_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int PIXEL_BITS  = 2,
    parameter int LINE_WIDTH  = 320,
    parameter int COORD_BITS  = 9,
    parameter int SPRITE_BITS = 6
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_n,
    input  logic                           i_Attr_Wr,
    input  logic [$clog2(NUM_SPRITES)-1:0] i_Attr_Sel,
    input  logic [1:0]                     i_Attr_Field,
    input  logic [COORD_BITS-1:0]          i_Attr_Data,
    input  logic                           i_Line_Start,
    input  logic [COORD_BITS-1:0]          i_Next_Line,
    output logic [SPRITE_BITS-1:0]         o_Rom_Sprite,
    output logic [2:0]                     o_Rom_Row,
    output logic [2:0]                     o_Rom_Col,
    input  logic [PIXEL_BITS-1:0]          i_Rom_Pixel,
    input  logic [COORD_BITS-1:0]          i_Rd_X,
    input  logic                           i_Rd_En,
    output logic [PIXEL_BITS-1:0]          o_Rd_Pixel,
    output logic                           o_Busy,
    output logic                           o_Late
);

    localparam int SEL_BITS = $clog2(NUM_SPRITES);
    localparam logic [COORD_BITS:0] X_LIMIT = (COORD_BITS+1)'(LINE_WIDTH);

    logic [COORD_BITS-1:0]  x_r   [NUM_SPRITES];
    logic [COORD_BITS-1:0]  y_r   [NUM_SPRITES];
    logic [SPRITE_BITS-1:0] num_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] en_r;
    logic [NUM_SPRITES-1:0] fv_r;
    logic [NUM_SPRITES-1:0] fh_r;
    logic                   attr_ctrl;

    assign attr_ctrl = i_Attr_Wr && (i_Attr_Field == ATTR_CTRL);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            en_r <= '0;
        end else if (attr_ctrl) begin
            en_r[i_Attr_Sel] <= i_Attr_Data[SPRITE_BITS+2];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Attr_Wr) begin
            case (i_Attr_Field)
                ATTR_X: x_r[i_Attr_Sel] <= i_Attr_Data;
                ATTR_Y: y_r[i_Attr_Sel] <= i_Attr_Data;
                ATTR_CTRL: begin
                    fv_r[i_Attr_Sel]  <= i_Attr_Data[SPRITE_BITS+1];
                    fh_r[i_Attr_Sel]  <= i_Attr_Data[SPRITE_BITS];
                    num_r[i_Attr_Sel] <= i_Attr_Data[SPRITE_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

    state_t                 state_q;
    state_t                 state_d;
    logic [SEL_BITS-1:0]    k_q;
    logic [SEL_BITS-1:0]    k_d;
    logic [2:0]             col_q;
    logic [2:0]             col_d;
    logic [COORD_BITS-1:0]  line_q;
    logic [COORD_BITS:0]    dy;
    logic                   visible;
    logic                   last_slot;
    logic                   snap;

    // Extra top bit catches Y above the line, so sprites never wrap vertically.
    assign dy = {1'b0, line_q} - {1'b0, y_r[k_q]};
    assign visible = en_r[k_q] && !dy[COORD_BITS]
                     && (dy[COORD_BITS-1:0] < COORD_BITS'(SPRITE_DIM));
    assign last_slot = (k_q == '0);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        snap    = 1'b0;
        if (i_Line_Start) begin
            state_d = ST_EVAL;
            k_d     = '1;
            col_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_EVAL: begin
                    if (visible) begin
                        snap    = 1'b1;
                        state_d = ST_FETCH;
                        col_d   = '0;
                    end else if (last_slot) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
                ST_FETCH: begin
                    col_d = col_q + 1'b1;
                    if (col_q == 3'(SPRITE_DIM - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_slot) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = ST_EVAL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic [COORD_BITS-1:0]  snap_x;
    logic [SPRITE_BITS-1:0] snap_num;
    logic [2:0]             snap_row;
    logic [2:0]             row_sel;
    logic [2:0]             pix_col_q;

`ifdef SPRITE_FLIP_EN
    logic snap_fh;

    assign row_sel   = fv_r[k_q] ? ~dy[2:0] : dy[2:0];
    assign o_Rom_Col = snap_fh ? ~col_q : col_q;

    always_ff @(posedge i_Clk) begin
        if (snap) begin
            snap_fh <= fh_r[k_q];
        end
    end
`else
    logic unused_flip;

    assign unused_flip = ^{fv_r, fh_r};
    assign row_sel     = dy[2:0];
    assign o_Rom_Col   = col_q;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Line_Start) begin
            line_q <= i_Next_Line;
        end
        if (snap) begin
            snap_x   <= x_r[k_q];
            snap_num <= num_r[k_q];
            snap_row <= row_sel;
        end
        pix_col_q <= col_q;
    end

    assign o_Rom_Sprite = snap_num;
    assign o_Rom_Row    = snap_row;

    logic                  rd_bank_q;
    logic                  late_q;
    logic                  pix_v_q;
    logic                  rd_ok_q;
    logic                  rd_sel_q;
    logic                  rd_hit;
    logic                  ren_we;
    logic [COORD_BITS:0]   wr_x;
    logic [PIXEL_BITS-1:0] q0;
    logic [PIXEL_BITS-1:0] q1;

    // ROM data trails the address by one cycle, so the column rides along.
    assign wr_x   = {1'b0, snap_x} + (COORD_BITS+1)'(pix_col_q);
    assign ren_we = pix_v_q && (i_Rom_Pixel != '0)
                    && (wr_x < X_LIMIT) && !i_Line_Start;
    assign rd_hit = i_Rd_En && ({1'b0, i_Rd_X} < X_LIMIT);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            rd_bank_q <= 1'b0;
            late_q    <= 1'b0;
            pix_v_q   <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            if (i_Line_Start) begin
                rd_bank_q <= ~rd_bank_q;
                if (state_q != ST_IDLE) begin
                    late_q <= 1'b1;
                end
            end
            pix_v_q  <= (state_q == ST_FETCH) && !i_Line_Start;
            rd_ok_q  <= rd_hit;
            rd_sel_q <= rd_bank_q;
        end
    end

    sprite_line_bank #(
        .DEPTH     (LINE_WIDTH),
        .DATA_BITS (PIXEL_BITS),
        .ADDR_BITS (COORD_BITS)
    ) u_bank0 (
        .clk      (i_Clk),
        .display  (~rd_bank_q),
        .ren_we   (ren_we),
        .ren_addr (wr_x[COORD_BITS-1:0]),
        .ren_data (i_Rom_Pixel),
        .clr_we   (rd_hit),
        .clr_addr (i_Rd_X),
        .rd_addr  (i_Rd_X),
        .rd_data  (q0)
    );

    sprite_line_bank #(
        .DEPTH     (LINE_WIDTH),
        .DATA_BITS (PIXEL_BITS),
        .ADDR_BITS (COORD_BITS)
    ) u_bank1 (
        .clk      (i_Clk),
        .display  (rd_bank_q),
        .ren_we   (ren_we),
        .ren_addr (wr_x[COORD_BITS-1:0]),
        .ren_data (i_Rom_Pixel),
        .clr_we   (rd_hit),
        .clr_addr (i_Rd_X),
        .rd_addr  (i_Rd_X),
        .rd_data  (q1)
    );

    assign o_Rd_Pixel = rd_ok_q ? (rd_sel_q ? q1 : q0) : '0;
    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Late     = late_q;

endmodule

// File: tb/tb_multi_sprite_line_engine.sv
// Directed bench for multi_sprite_line_engine with a line-level model.
// Honours SPRITE_FLIP_EN the same way as the design.
module tb_multi_sprite_line_engine;

    localparam int N = 8;
    localparam int W = 320;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       attr_wr    = 1'b0;
    logic [2:0] attr_sel   = '0;
    logic [1:0] attr_field = '0;
    logic [8:0] attr_data  = '0;
    logic       line_start = 1'b0;
    logic [8:0] next_line  = '0;
    logic [5:0] rom_sprite;
    logic [2:0] rom_row;
    logic [2:0] rom_col;
    logic [1:0] rom_pixel  = '0;
    logic [8:0] rd_x       = '0;
    logic       rd_en      = 1'b0;
    logic [1:0] rd_pixel;
    logic       busy;
    logic       late;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    multi_sprite_line_engine dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Attr_Wr    (attr_wr),
        .i_Attr_Sel   (attr_sel),
        .i_Attr_Field (attr_field),
        .i_Attr_Data  (attr_data),
        .i_Line_Start (line_start),
        .i_Next_Line  (next_line),
        .o_Rom_Sprite (rom_sprite),
        .o_Rom_Row    (rom_row),
        .o_Rom_Col    (rom_col),
        .i_Rom_Pixel  (rom_pixel),
        .i_Rd_X       (rd_x),
        .i_Rd_En      (rd_en),
        .o_Rd_Pixel   (rd_pixel),
        .o_Busy       (busy),
        .o_Late       (late)
    );

    function automatic int rom(input int s, input int r, input int c);
        return (s + r + c) & 3;
    endfunction

    always @(posedge clk)
        rom_pixel <= 2'(rom(int'(rom_sprite), int'(rom_row), int'(rom_col)));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: sprite attributes, two line images, and the busy countdown.
    int m_x[N];
    int m_y[N];
    int m_ctrl[N];
    int mbuf[2][W];
    bit mknown[2][W];
    int m_rb      = 0;
    int m_rem     = 0;
    bit m_late    = 1'b0;
    int exp_px    = 0;
    bit exp_known = 1'b1;

    function automatic int m_render(input int line, input int b);
        int cyc = 0;
        for (int k = N - 1; k >= 0; k--) begin
            int dy  = line - m_y[k];
            int num = m_ctrl[k] & 63;
            bit en  = ((m_ctrl[k] >> 8) & 1) != 0;
            if (en && dy >= 0 && dy < 8) begin
                cyc += 10;
                for (int c = 0; c < 8; c++) begin
                    int rr = dy;
                    int cc = c;
                    int px = m_x[k] + c;
                    int p;
`ifdef SPRITE_FLIP_EN
                    if (((m_ctrl[k] >> 7) & 1) != 0) rr = 7 - dy;
                    if (((m_ctrl[k] >> 6) & 1) != 0) cc = 7 - c;
`endif
                    p = rom(num, rr, cc);
                    if (p != 0 && px < W) begin
                        mbuf[b][px]   = p;
                        mknown[b][px] = 1'b1;
                    end
                end
            end else begin
                cyc += 1;
            end
        end
        return cyc;
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            m_rb      = 0;
            m_rem     = 0;
            m_late    = 1'b0;
            exp_px    = 0;
            exp_known = 1'b1;
            for (int k = 0; k < N; k++) m_ctrl[k] = m_ctrl[k] & ~256;
            return;
        end
        exp_px    = 0;
        exp_known = 1'b1;
        if (rd_en && int'(rd_x) < W) begin
            exp_px    = mbuf[m_rb][rd_x];
            exp_known = mknown[m_rb][rd_x];
            mbuf[m_rb][rd_x]   = 0;
            mknown[m_rb][rd_x] = 1'b1;
        end
        if (attr_wr) begin
            case (attr_field)
                2'd0: m_x[attr_sel] = int'(attr_data);
                2'd1: m_y[attr_sel] = int'(attr_data);
                2'd2: m_ctrl[attr_sel] = int'(attr_data);
                default: ;
            endcase
        end
        if (line_start) begin
            if (m_rem > 0) begin
                m_late = 1'b1;
                for (int i = 0; i < W; i++) mknown[1 - m_rb][i] = 1'b0;
            end
            m_rb  = 1 - m_rb;
            m_rem = m_render(int'(next_line), 1 - m_rb);
        end else if (m_rem > 0) begin
            m_rem--;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", int'(busy), int'(m_rem > 0));
            check("late", int'(late), int'(m_late));
            if (exp_known) check("rd_pixel", int'(rd_pixel), exp_px);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic int ctrl(input int en, input int fv,
                                input int fh, input int num);
        return (en << 8) | (fv << 7) | (fh << 6) | num;
    endfunction

    task automatic attr(input int sel, input int field, input int data);
        attr_wr    = 1'b1;
        attr_sel   = 3'(sel);
        attr_field = 2'(field);
        attr_data  = 9'(data);
        step();
        attr_wr    = 1'b0;
    endtask

    task automatic start(input int line);
        line_start = 1'b1;
        next_line  = 9'(line);
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        if (busy) check("busy_timeout", 1, 0);
    endtask

    task automatic read_px(input int x, input int exp, input string name);
        rd_en = 1'b1;
        rd_x  = 9'(x);
        step();
        rd_en = 1'b0;
        check(name, int'(rd_pixel), exp);
    endtask

    task automatic sweep();
        for (int x = 0; x < W; x++) begin
            rd_en = 1'b1;
            rd_x  = 9'(x);
            step();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clk);
        idle(3);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Flush both buffers and drive o_Late high before the real reset.
        start(400);
        idle(2);
        start(400);
        check("pre_late", int'(late), 1);
        wait_idle(n);
        sweep();
        start(401);
        wait_idle(n);
        sweep();

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_late", int'(late), 0);
        check("rst_pixel", int'(rd_pixel), 0);

        start(5);
        wait_idle(n);
        check("t1_busy_cycles", n, 8);
        start(6);
        wait_idle(n);
        read_px(100, 0, "t1_x100");
        sweep();

        attr(0, 0, 10);
        attr(0, 1, 20);
        attr(0, 2, ctrl(1, 0, 0, 3));
        start(22);
        wait_idle(n);
        check("t2_busy_cycles", n, 17);
        start(0);
        wait_idle(n);
        read_px(9, 0, "t2_x9");
        read_px(10, 1, "t2_x10");
        read_px(12, 3, "t2_x12");
        read_px(13, 0, "t2_x13");
        read_px(18, 0, "t2_x18");
        sweep();

        attr(5, 0, 10);
        attr(5, 1, 20);
        attr(5, 2, ctrl(1, 0, 0, 1));
        start(22);
        wait_idle(n);
        check("t3_busy_cycles", n, 26);
        start(0);
        wait_idle(n);
        read_px(10, 1, "t3_x10");
        read_px(13, 2, "t3_x13");
        read_px(17, 2, "t3_x17");
        sweep();

        attr(5, 2, ctrl(0, 0, 0, 1));
        attr(1, 0, 316);
        attr(1, 1, 100);
        attr(1, 2, ctrl(1, 0, 0, 2));
        start(103);
        wait_idle(n);
        start(0);
        wait_idle(n);
        read_px(316, 1, "t4_x316");
        read_px(318, 3, "t4_x318");
        read_px(0, 0, "t4_x0");
        read_px(400, 0, "t4_x400");
        sweep();
        attr(1, 1, 511);
        start(0);
        wait_idle(n);
        check("t4_wrap_busy", n, 8);
        start(1);
        wait_idle(n);
        read_px(316, 0, "t4_wrap_x316");
        sweep();

        attr(2, 0, 50);
        attr(2, 1, 20);
        attr(2, 2, ctrl(1, 0, 0, 4));
        start(22);
        idle(19);
        start(22);
        check("t5_late", int'(late), 1);
        sweep();
        wait_idle(n);
        start(0);
        wait_idle(n);
        read_px(10, 1, "t5_x10");
        read_px(10, 0, "t6_second_read");
        read_px(50, 2, "t5_x50");
        sweep();

        attr(0, 2, ctrl(1, 0, 1, 2));
        start(22);
        wait_idle(n);
        start(0);
        wait_idle(n);
`ifdef SPRITE_FLIP_EN
        read_px(10, 3, "t6_flip_x10");
        read_px(11, 2, "t6_flip_x11");
`else
        read_px(10, 0, "t6_noflip_x10");
        read_px(11, 1, "t6_noflip_x11");
`endif
        sweep();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
